// File: rtl/spp_f2i_pipelined.sv
// Three-stage IEEE-754 single to 32-bit integer converter with valid/ready flow control.
// Optional build macro SPP_F2I_ROUND_NEAREST_EN selects round-to-nearest-even instead of truncation.
module spp_f2i_pipelined #(
  parameter int SIGNED_OUT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] c,
  output logic        flag_invalid,
  output logic        flag_overflow,
  output logic        flag_inexact
);

  // S1: unpack / classify
  logic        v1, sign1, nan1, inf1, zero1;
  logic [7:0]  exp1;
  logic [22:0] man1;
  // S2: aligned magnitude with guard/sticky
  logic        v2, sign2, nan2, big2, guard2, sticky2;
  logic [31:0] mag2;

  logic              advance;
  logic signed [8:0] e;
  logic [5:0]        sh;
  logic [63:0]       wide;
  logic [31:0]       mag_d;
  logic              big_d, guard_d, sticky_d;
  logic              round_up;
  logic [32:0]       rmag;
  logic [31:0]       c_d;
  logic              inv_d, ovf_d, inx_d;

  assign in_ready = out_ready | ~out_valid;
  assign advance  = in_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1 <= 1'b0; sign1 <= 1'b0; nan1 <= 1'b0; inf1 <= 1'b0; zero1 <= 1'b0;
      exp1 <= 8'd0; man1 <= 23'd0;
    end else if (advance) begin
      v1    <= in_valid;
      sign1 <= a[31];
      exp1  <= a[30:23];
      man1  <= a[22:0];
      nan1  <= (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
      inf1  <= (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
      zero1 <= (a[30:23] == 8'h00);
    end
  end

  // Value scaled by 2^32 puts the integer part in wide[63:32] and the fraction below it.
  always_comb begin
    e        = $signed({1'b0, exp1}) - 9'sd127;
    sh       = e[5:0] + 6'd9;
    wide     = {40'd0, 1'b1, man1} << sh;
    mag_d    = 32'd0;
    big_d    = 1'b0;
    guard_d  = 1'b0;
    sticky_d = 1'b0;
    if (nan1 || inf1) begin
      big_d = inf1;
    end else if (zero1) begin
      sticky_d = |man1;
    end else if (e < 9'sd0) begin
      guard_d  = (e == -9'sd1);
      sticky_d = (e != -9'sd1) | (|man1);
    end else if (e > 9'sd31) begin
      big_d = 1'b1;
    end else begin
      mag_d    = wide[63:32];
      guard_d  = wide[31];
      sticky_d = |wide[30:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v2 <= 1'b0; sign2 <= 1'b0; nan2 <= 1'b0; big2 <= 1'b0;
      guard2 <= 1'b0; sticky2 <= 1'b0; mag2 <= 32'd0;
    end else if (advance) begin
      v2      <= v1;
      sign2   <= sign1;
      nan2    <= nan1;
      big2    <= big_d;
      guard2  <= guard_d;
      sticky2 <= sticky_d;
      mag2    <= mag_d;
    end
  end

  // S3: round, then saturate on the rounded magnitude so a carry-out is caught.
  always_comb begin
`ifdef SPP_F2I_ROUND_NEAREST_EN
    round_up = guard2 & (sticky2 | mag2[0]);
`else
    round_up = 1'b0;
`endif
    rmag  = {1'b0, mag2} + {32'd0, round_up};
    c_d   = 32'd0;
    inv_d = 1'b0;
    ovf_d = 1'b0;
    inx_d = guard2 | sticky2;
    if (nan2) begin
      c_d   = (SIGNED_OUT != 0) ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
      inv_d = 1'b1;
    end else if (SIGNED_OUT != 0) begin
      if (!sign2) begin
        if (big2 || rmag > 33'h0_7FFF_FFFF) begin
          c_d = 32'h7FFF_FFFF; ovf_d = 1'b1;
        end else begin
          c_d = rmag[31:0];
        end
      end else if (big2 || rmag > 33'h0_8000_0000) begin
        c_d = 32'h8000_0000; ovf_d = 1'b1;
      end else begin
        c_d = ~rmag[31:0] + 32'd1;
      end
    end else begin
      if (!sign2) begin
        if (big2 || rmag[32]) begin
          c_d = 32'hFFFF_FFFF; ovf_d = 1'b1;
        end else begin
          c_d = rmag[31:0];
        end
      end else if (big2 || rmag != 33'd0) begin
        ovf_d = 1'b1;
      end
    end
    if (ovf_d || inv_d) inx_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid     <= 1'b0;
      c             <= 32'd0;
      flag_invalid  <= 1'b0;
      flag_overflow <= 1'b0;
      flag_inexact  <= 1'b0;
    end else if (advance) begin
      out_valid <= v2;
      if (v2) begin
        c             <= c_d;
        flag_invalid  <= inv_d;
        flag_overflow <= ovf_d;
        flag_inexact  <= inx_d;
      end
    end
  end

endmodule
